// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over 8N1 UART, writes it to
// program memory as little-endian words and releases the CPU core once the image is complete.
module uart_program_loader #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int MAX_WORDS   = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_rx,
    output logic        prog_write_enable,
    output logic [31:0] prog_byte_address,
    output logic [31:0] prog_write_data,
    output logic        cpu_reset_n,
    output logic        load_done,
    output logic        load_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_LEN_LO, L_LEN_HI, L_WORD, L_DONE, L_ERROR} ld_state_t;

    logic [1:0]       sync_r;
    logic             rx_s;
    rx_state_t        rx_state_r, rx_state_nxt;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             byte_valid_r;
    logic             frame_err_r;
    logic             baud_clr_s, data_sample_s, byte_ok_s, frame_bad_s;
    logic             half_tick_s, bit_tick_s;

    ld_state_t        ld_state_r, ld_state_nxt;
    logic [7:0]       len_lo_r;
    logic [15:0]      len_r;
    logic [15:0]      len_full_s;
    logic [1:0]       byte_idx_r;
    logic [15:0]      word_idx_r;
    logic [23:0]      word_buf_r;
    logic             word_issue_s;
    logic             write_en_r;
    logic [31:0]      addr_r;
    logic [31:0]      data_r;
    logic             cpu_reset_n_r;
    logic             load_done_r;
    logic             load_error_r;

    assign rx_s       = sync_r[1];
    assign len_full_s = {shift_r, len_lo_r};

    // Two-flop synchronizer; resets to the idle-high line level so no false start is seen.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], io_rx};
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_r <= R_IDLE;
        end else begin
            rx_state_r <= rx_state_nxt;
        end
    end

    // Receiver next-state and sampling strobes.
    always_comb begin
        rx_state_nxt  = rx_state_r;
        baud_clr_s    = 1'b0;
        data_sample_s = 1'b0;
        byte_ok_s     = 1'b0;
        frame_bad_s   = 1'b0;
        half_tick_s   = (baud_cnt_r == CNT_W'(HALF_BIT - 1));
        bit_tick_s    = (baud_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
        case (rx_state_r)
            R_IDLE: begin
                if (!rx_s) begin
                    rx_state_nxt = R_START;
                    baud_clr_s   = 1'b1;
                end else begin
                    rx_state_nxt = R_IDLE;
                end
            end
            R_START: begin
                if (half_tick_s) begin
                    baud_clr_s   = 1'b1;
                    rx_state_nxt = rx_s ? R_IDLE : R_DATA;
                end else begin
                    rx_state_nxt = R_START;
                end
            end
            R_DATA: begin
                if (bit_tick_s) begin
                    baud_clr_s    = 1'b1;
                    data_sample_s = 1'b1;
                    rx_state_nxt  = (bit_cnt_r == 3'd7) ? R_STOP : R_DATA;
                end else begin
                    rx_state_nxt = R_DATA;
                end
            end
            R_STOP: begin
                if (bit_tick_s) begin
                    baud_clr_s   = 1'b1;
                    rx_state_nxt = R_IDLE;
                    if (rx_s) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        frame_bad_s = 1'b1;
                    end
                end else begin
                    rx_state_nxt = R_STOP;
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // Receiver datapath: baud counter restarts at every start detection, bits shift in LSB first.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            baud_cnt_r   <= {CNT_W{1'b0}};
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (baud_clr_s || rx_state_r == R_IDLE) begin
                baud_cnt_r <= {CNT_W{1'b0}};
            end else begin
                baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            end
            if (rx_state_r == R_START) begin
                bit_cnt_r <= 3'd0;
            end else if (data_sample_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
            if (data_sample_s) begin
                shift_r <= {rx_s, shift_r[7:1]};
            end
            byte_valid_r <= byte_ok_s;
            frame_err_r  <= frame_bad_s;
        end
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_state_r <= L_LEN_LO;
        end else begin
            ld_state_r <= ld_state_nxt;
        end
    end

    // Loader next-state; completion waits for the final strobe so load_done trails it by one cycle.
    always_comb begin
        ld_state_nxt = ld_state_r;
        word_issue_s = 1'b0;
        case (ld_state_r)
            L_LEN_LO: begin
                if (frame_err_r) begin
                    ld_state_nxt = L_ERROR;
                end else if (byte_valid_r) begin
                    ld_state_nxt = L_LEN_HI;
                end else begin
                    ld_state_nxt = L_LEN_LO;
                end
            end
            L_LEN_HI: begin
                if (frame_err_r) begin
                    ld_state_nxt = L_ERROR;
                end else if (byte_valid_r) begin
                    if (len_full_s == 16'd0) begin
                        ld_state_nxt = L_DONE;
                    end else if ({1'b0, len_full_s} > 17'(MAX_WORDS)) begin
                        ld_state_nxt = L_ERROR;
                    end else begin
                        ld_state_nxt = L_WORD;
                    end
                end else begin
                    ld_state_nxt = L_LEN_HI;
                end
            end
            L_WORD: begin
                if (frame_err_r) begin
                    ld_state_nxt = L_ERROR;
                end else if (write_en_r && word_idx_r == len_r) begin
                    ld_state_nxt = L_DONE;
                end else if (byte_valid_r && byte_idx_r == 2'd3) begin
                    word_issue_s = 1'b1;
                    ld_state_nxt = L_WORD;
                end else begin
                    ld_state_nxt = L_WORD;
                end
            end
            L_DONE:  ld_state_nxt = L_DONE;
            L_ERROR: ld_state_nxt = L_ERROR;
            default: ld_state_nxt = L_ERROR;
        endcase
    end

    // Loader datapath: length capture, word assembly and the registered write port / status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_lo_r      <= 8'h00;
            len_r         <= 16'd0;
            byte_idx_r    <= 2'd0;
            word_idx_r    <= 16'd0;
            word_buf_r    <= 24'h000000;
            write_en_r    <= 1'b0;
            addr_r        <= 32'h0000_0000;
            data_r        <= 32'h0000_0000;
            cpu_reset_n_r <= 1'b0;
            load_done_r   <= 1'b0;
            load_error_r  <= 1'b0;
        end else begin
            if (ld_state_r == L_LEN_LO && byte_valid_r) begin
                len_lo_r <= shift_r;
            end
            if (ld_state_r == L_LEN_HI && byte_valid_r) begin
                len_r <= len_full_s;
            end
            if (ld_state_r == L_WORD && byte_valid_r && byte_idx_r != 2'd3) begin
                word_buf_r[{byte_idx_r, 3'b000} +: 8] <= shift_r;
            end
            if (ld_state_r == L_WORD && byte_valid_r) begin
                byte_idx_r <= byte_idx_r + 2'd1;
            end
            write_en_r <= word_issue_s;
            if (word_issue_s) begin
                data_r     <= {shift_r, word_buf_r};
                addr_r     <= {14'd0, word_idx_r, 2'b00};
                word_idx_r <= word_idx_r + 16'd1;
            end
            cpu_reset_n_r <= (ld_state_nxt == L_DONE);
            load_done_r   <= (ld_state_nxt == L_DONE);
            load_error_r  <= (ld_state_nxt == L_ERROR);
        end
    end

    assign prog_write_enable = write_en_r;
    assign prog_byte_address = addr_r;
    assign prog_write_data   = data_r;
    assign cpu_reset_n       = cpu_reset_n_r;
    assign load_done         = load_done_r;
    assign load_error        = load_error_r;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at 16 clocks per bit and a 4-word program memory.
module tb_uart_program_loader;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_rx = 1'b1;
    logic        prog_write_enable;
    logic [31:0] prog_byte_address;
    logic [31:0] prog_write_data;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    int          wr_n = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_cyc  [16];
    int          done_cyc = -1;
    logic        done_prev = 1'b0;
    int          base;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD_RATE  (100_000),
        .MAX_WORDS  (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .io_rx            (io_rx),
        .prog_write_enable(prog_write_enable),
        .prog_byte_address(prog_byte_address),
        .prog_write_data  (prog_write_data),
        .cpu_reset_n      (cpu_reset_n),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    // Write-port and completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (prog_write_enable) begin
            if (wr_n < 16) begin
                wr_addr[wr_n] <= prog_byte_address;
                wr_data[wr_n] <= prog_write_data;
                wr_cyc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
        done_prev <= load_done;
        if (load_done && !done_prev) begin
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bit_drive(input logic v);
        io_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bit_drive(1'b0);
        for (int i = 0; i < 8; i++) bit_drive(b[i]);
        bit_drive(stop_bit);
        io_rx = 1'b1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        io_rx   = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, "_rst_we"},   {31'd0, prog_write_enable}, 32'd0);
        chk({tag, "_rst_addr"}, prog_byte_address, 32'd0);
        chk({tag, "_rst_cpu"},  {31'd0, cpu_reset_n}, 32'd0);
        chk({tag, "_rst_done"}, {31'd0, load_done}, 32'd0);
        chk({tag, "_rst_err"},  {31'd0, load_error}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Test 1: two-word image.
        do_reset("t1");
        base = wr_n;
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("t1_nwr", wr_n - base, 32'd2);
        chk("t1_a0", wr_addr[base], 32'h0000_0000);
        chk("t1_d0", wr_data[base], 32'hDEAD_BEEF);
        chk("t1_a1", wr_addr[base+1], 32'h0000_0004);
        chk("t1_d1", wr_data[base+1], 32'h0000_0013);
        chk("t1_done_lat", done_cyc - wr_cyc[base+1], 32'd1);
        chk("t1_cpu", {31'd0, cpu_reset_n}, 32'd1);
        chk("t1_done", {31'd0, load_done}, 32'd1);
        chk("t1_err", {31'd0, load_error}, 32'd0);

        // Test 2: empty image.
        do_reset("t2");
        base = wr_n;
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("t2_nwr", wr_n - base, 32'd0);
        chk("t2_done", {31'd0, load_done}, 32'd1);
        chk("t2_cpu", {31'd0, cpu_reset_n}, 32'd1);
        chk("t2_err", {31'd0, load_error}, 32'd0);

        // Test 3: length above capacity, trailing bytes ignored.
        do_reset("t3");
        base = wr_n;
        send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1);
        repeat (5) @(negedge clk);
        chk("t3_err_hdr", {31'd0, load_error}, 32'd1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        repeat (20) @(negedge clk);
        chk("t3_nwr", wr_n - base, 32'd0);
        chk("t3_err", {31'd0, load_error}, 32'd1);
        chk("t3_cpu", {31'd0, cpu_reset_n}, 32'd0);
        chk("t3_done", {31'd0, load_done}, 32'd0);

        // Test 4: framing error on the first data byte.
        do_reset("t4");
        base = wr_n;
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hA5, 1'b0);
        repeat (4 * CPB) @(negedge clk);
        chk("t4_nwr", wr_n - base, 32'd0);
        chk("t4_err", {31'd0, load_error}, 32'd1);
        chk("t4_cpu", {31'd0, cpu_reset_n}, 32'd0);
        chk("t4_done", {31'd0, load_done}, 32'd0);

        // Test 5: short low glitch while idle, then a one-word image.
        do_reset("t5");
        base = wr_n;
        io_rx = 1'b0;
        repeat (5) @(negedge clk);
        io_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1); send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
        repeat (20) @(negedge clk);
        chk("t5_nwr", wr_n - base, 32'd1);
        chk("t5_a0", wr_addr[base], 32'h0000_0000);
        chk("t5_d0", wr_data[base], 32'h1234_5678);
        chk("t5_done", {31'd0, load_done}, 32'd1);
        chk("t5_err", {31'd0, load_error}, 32'd0);

        // Test 6: reset pulse mid-image, then the full test-1 image.
        do_reset("t6");
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h99, 1'b1); send_byte(8'h88, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_mid_done", {31'd0, load_done}, 32'd0);
        base = wr_n;
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
        send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_nwr", wr_n - base, 32'd2);
        chk("t6_a0", wr_addr[base], 32'h0000_0000);
        chk("t6_d0", wr_data[base], 32'hDEAD_BEEF);
        chk("t6_a1", wr_addr[base+1], 32'h0000_0004);
        chk("t6_d1", wr_data[base+1], 32'h0000_0013);
        chk("t6_done_lat", done_cyc - wr_cyc[base+1], 32'd1);
        chk("t6_cpu", {31'd0, cpu_reset_n}, 32'd1);
        chk("t6_err", {31'd0, load_error}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
